// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues synchronous imem reads,
// buffers {pc, inst} pairs in a small queue and hands them to ID with valid/ready.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd1,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // Handshake: an entry transfers to ID in a cycle where id_valid && id_ready at the
   // rising edge; id_pc/id_inst are stable and meaningful only while id_valid is high.

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   q_pc_q [DEPTH];
   logic [31:0]   q_pc_d [DEPTH];
   logic [31:0]   q_inst_q [DEPTH];
   logic [31:0]   q_inst_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          kill_q, kill_d;
   logic          pop, issue, write;
   logic [CW:0]   occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      id_valid  = (count_q != '0) & !redirect & !rst;
      id_pc     = q_pc_q[head_q];
      id_inst   = q_inst_q[head_q];
      pop       = id_valid & id_ready;
      // Credit: queued entries plus the outstanding response must leave room after this pop.
      occupancy = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
      issue     = !rst & !redirect & (occupancy < (CW+1)'(DEPTH));
      imem_en   = issue;
      imem_addr = fetch_pc_q;
      write     = inflight_q & !kill_q & !redirect;
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
      kill_d        = kill_q & !inflight_q;
      q_pc_d        = q_pc_q;
      q_inst_d      = q_inst_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         // A fetch issued alongside a redirect would be stale; issue is blocked, so this stays 0.
         kill_d     = issue;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
         if (write) begin
            q_pc_d[tail_q]   = inflight_pc_q;
            q_inst_d[tail_q] = imem_data;
            tail_d           = ptr_inc(tail_q);
         end
         if (pop) head_d = ptr_inc(head_q);
         count_d = count_q + CW'(write) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         kill_q        <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         kill_q        <= kill_d;
      end
   end

   always_ff @(posedge clk) begin
      q_pc_q   <= q_pc_d;
      q_inst_q <= q_inst_d;
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: startup/stall vector table, redirect/reset/wrap sequences,
// and a randomized stall+redirect run checked against an architectural PC stream.
module tb_fetch_unit;
   localparam logic [31:0] XK = 32'hA5A5_0000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, redirect = 1'b0, id_ready = 1'b0;
   logic [31:0] redirect_pc = '0, imem_data = '0;
   logic        imem_en, id_valid;
   logic [31:0] imem_addr, id_pc, id_inst;

   logic        rst_w = 1'b1, redirect_w = 1'b0, id_ready_w = 1'b1;
   logic [31:0] redirect_pc_w = '0, imem_data_w = '0;
   logic        imem_en_w, id_valid_w;
   logic [31:0] imem_addr_w, id_pc_w, id_inst_w;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_w (
      .clk(clk), .rst(rst_w), .imem_en(imem_en_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
      .redirect(redirect_w), .redirect_pc(redirect_pc_w), .id_ready(id_ready_w),
      .id_valid(id_valid_w), .id_pc(id_pc_w), .id_inst(id_inst_w)
   );

   // Synchronous instruction memories: data one cycle after the strobe.
   always @(posedge clk) if (imem_en) imem_data <= imem_addr ^ XK;
   always @(posedge clk) if (imem_en_w) imem_data_w <= imem_addr_w ^ XK;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];
   logic [31:0] push_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      rst = r; id_ready = rdy; redirect = rd; redirect_pc = rpc;
      #1;
   endtask

   task automatic sb_push();
      exp_q.push_back({push_pc, push_pc ^ XK});
      push_pc = push_pc + 32'd1;
   endtask

   task automatic sb_restart(input logic [31:0] pc);
      exp_q.delete();
      push_pc = pc;
      for (int i = 0; i < 4; i++) sb_push();
   endtask

   typedef struct packed {
      logic        rst;
      logic        rdy;
      logic        en;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
   } vec_t;
   vec_t vt[16];

   initial begin
      logic [63:0] e;
      logic rdy, rd, pop;
      logic [31:0] rpc, issue_pc;
      int out, pops;

      vt[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
      vt[1]  = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
      vt[2]  = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0};
      vt[3]  = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'd0};
      vt[4]  = '{1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'd1};
      vt[5]  = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b1, 32'd2};
      vt[6]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0};
      vt[8]  = '{1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
      vt[11] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
      vt[13] = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'd0};
      vt[14] = '{1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'd1};
      vt[15] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b1, 32'd2};

      for (int i = 0; i < 16; i++) begin
         step(vt[i].rst, vt[i].rdy, 1'b0, 32'd0);
         chk($sformatf("tbl%0d_en", i), 32'(imem_en), 32'(vt[i].en));
         if (vt[i].en) chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].addr);
         chk($sformatf("tbl%0d_valid", i), 32'(id_valid), 32'(vt[i].vld));
         if (vt[i].vld) begin
            chk($sformatf("tbl%0d_pc", i), id_pc, vt[i].pc);
            chk($sformatf("tbl%0d_inst", i), id_inst, vt[i].pc ^ XK);
         end
      end

      // Redirect with pc0 queued and pc1 in flight.
      step(1'b1, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b1, 32'h40);
      chk("redir_valid", 32'(id_valid), 32'd0);
      chk("redir_en", 32'(imem_en), 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("redir_r1_en", 32'(imem_en), 32'd1);
      chk("redir_r1_addr", imem_addr, 32'h40);
      chk("redir_r1_valid", 32'(id_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("redir_r2_addr", imem_addr, 32'h41);
      chk("redir_r2_valid", 32'(id_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("redir_r3_valid", 32'(id_valid), 32'd1);
      chk("redir_r3_pc", id_pc, 32'h40);
      chk("redir_r3_inst", id_inst, 32'h40 ^ XK);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("redir_r4_pc", id_pc, 32'h41);

      // Fill the queue from 0x100, then reset mid-stream.
      step(1'b0, 1'b0, 1'b1, 32'h100);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
      chk("full_valid", 32'(id_valid), 32'd1);
      chk("full_pc", id_pc, 32'h100);
      chk("full_en", 32'(imem_en), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("mrst_valid", 32'(id_valid), 32'd0);
      chk("mrst_en", 32'(imem_en), 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("mrst_r1_valid", 32'(id_valid), 32'd0);
      chk("mrst_r1_addr", imem_addr, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("mrst_r2_valid", 32'(id_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("mrst_r3_valid", 32'(id_valid), 32'd1);
      chk("mrst_r3_pc", id_pc, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("mrst_r4_pc", id_pc, 32'd1);

      // PC wrap on the second instance.
      @(negedge clk); rst_w = 1'b0; #1;
      chk("wrap_a0", imem_addr_w, 32'hFFFF_FFFE);
      chk("wrap_v0", 32'(id_valid_w), 32'd0);
      @(negedge clk); #1;
      chk("wrap_a1", imem_addr_w, 32'hFFFF_FFFF);
      @(negedge clk); #1;
      chk("wrap_a2", imem_addr_w, 32'h0000_0000);
      chk("wrap_pc0", id_pc_w, 32'hFFFF_FFFE);
      @(negedge clk); #1;
      chk("wrap_pc1", id_pc_w, 32'hFFFF_FFFF);
      @(negedge clk); #1;
      chk("wrap_pc2", id_pc_w, 32'h0000_0000);
      chk("wrap_inst2", id_inst_w, XK);

      // Random stalls and redirects against the architectural stream.
      step(1'b1, 1'b1, 1'b0, 32'd0);
      sb_restart(32'd0);
      issue_pc = 32'd0;
      out = 0;
      pops = 0;
      for (int c = 0; c < 1000; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 24) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
         step(1'b0, rdy, rd, rpc);
         chk("credit", 32'(out <= 2), 32'd1);
         if (rd) begin
            chk("rnd_redir_valid", 32'(id_valid), 32'd0);
            chk("rnd_redir_en", 32'(imem_en), 32'd0);
            issue_pc = rpc;
            sb_restart(rpc);
            out = 0;
         end else begin
            pop = id_valid & id_ready;
            if (imem_en) begin
               chk("rnd_addr", imem_addr, issue_pc);
               issue_pc = issue_pc + 32'd1;
            end
            if (pop) begin
               pops++;
               if (exp_q.size() == 0) begin
                  chk("rnd_sb_empty", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rnd_pc", id_pc, e[63:32]);
                  chk("rnd_inst", id_inst, e[31:0]);
                  sb_push();
               end
            end
            out = out + int'(imem_en) - int'(pop);
         end
      end
      chk("rnd_progress", 32'(pops > 200), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
